// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: instruction-type codes, RV32I
// major opcodes, issue FSM encodings, decoder op-field layout and the
// instruction-queue entry payload.
package issue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 10;

    // Decoder op field {type[2:0], head[2:0], sub[3:0]}
    localparam int unsigned OP_TYPE_MSB = 9;
    localparam int unsigned OP_TYPE_LSB = 7;
    localparam int unsigned OP_HEAD_MSB = 6;
    localparam int unsigned OP_HEAD_LSB = 4;
    localparam int unsigned OP_SUB_MSB  = 3;
    localparam int unsigned OP_SUB_LSB  = 0;

    typedef enum logic [2:0] {
        TYPE_EMPTY = 3'd0,
        TYPE_R     = 3'd1,
        TYPE_I     = 3'd2,
        TYPE_S     = 3'd3,
        TYPE_B     = 3'd4,
        TYPE_U     = 3'd5,
        TYPE_J     = 3'd6
    } instr_type_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] npc;
    } iq_entry_t;

    // Instruction-type field of a decoder op word
    function automatic logic [2:0] op_type(input logic [OP_W-1:0] op);
        return op[OP_TYPE_MSB:OP_TYPE_LSB];
    endfunction

endpackage

// File: rtl/issue_queue.sv
// Circular instruction FIFO for the issue stage.
// Ports: clk_in, rst_in (sync, active-high), flush (clears pointers),
//        push/wdata (enqueue, ignored when full), pop (dequeue, ignored when
//        empty), head_data (head entry, zero when empty), count, full, empty.
// push/pop/flush are expected to be already qualified by the global enable.
module issue_queue #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 64
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + AW'(1);
            if (pop_ok)  head_q <= head_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset; validity is tracked by count
    always_ff @(posedge clk_in) begin
        if (!rst_in && !flush && push_ok) mem[tail_q] <= wdata;
    end

    assign head_data = empty ? '0 : mem[head_q];
    assign count     = count_q;

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage sequencer: buffers fetched instr/npc pairs, presents the head
// to the decoder and dispatches it to the RS or SLB with a ROB tag.
// Ports: clk_in/rst_in (sync active-high), rdy_in (global enable),
//        flush_in, fetch side if_*, decoder side dec_*, back-end full flags
//        and rob_tag_in, one-cycle dispatch strobes disp_*, halted_out.
// Optional: define ISSUE_STALL_STAT_EN to add stall_cycles_out and
//           disp_count_out saturating statistics counters.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned IQ_ADDR_WIDTH = 3,
    parameter int unsigned Q_WIDTH       = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               if_valid_in,
    input  logic [INSTR_W-1:0] if_instr_in,
    input  logic [INSTR_W-1:0] if_npc_in,
    output logic               if_ready_out,
    output logic [INSTR_W-1:0] dec_instr_out,
    output logic [INSTR_W-1:0] dec_npc_out,
    output logic               dec_has_instr_out,
    input  logic [OP_W-1:0]    dec_op_in,
    input  logic               dec_to_rs_in,
    input  logic               dec_to_slb_in,
    input  logic               rs_full_in,
    input  logic               slb_full_in,
    input  logic               rob_full_in,
    input  logic [Q_WIDTH-1:0] rob_tag_in,
    output logic               disp_rs_out,
    output logic               disp_slb_out,
    output logic               disp_rob_out,
    output logic [Q_WIDTH-1:0] disp_tag_out,
    output logic               halted_out
`ifdef ISSUE_STALL_STAT_EN
    ,
    output logic [31:0]        stall_cycles_out,
    output logic [31:0]        disp_count_out
`endif
);

    issue_state_e state_q;
    issue_state_e state_d;
    iq_entry_t    q_head;
    iq_entry_t    q_wdata;
    logic [IQ_ADDR_WIDTH:0] q_count;
    logic         q_full;
    logic         q_empty;
    logic         q_push;
    logic         q_pop;
    logic         has_instr;
    logic         op_valid;
    logic         target_ok;
    logic         go;
    logic         unused_op_bits;

    // Only the type field matters here; head/sub belong to the back-end
    assign unused_op_bits = ^dec_op_in[OP_HEAD_MSB:OP_SUB_LSB];

    assign has_instr = !q_empty;
    assign op_valid  = (op_type(dec_op_in) != 3'(TYPE_EMPTY));
    assign target_ok = dec_to_slb_in ? !slb_full_in : !rs_full_in;
    // STALL still counts as running so a stall clears without a bubble
    assign go = has_instr && !rob_full_in && target_ok && op_valid
             && (state_q != ST_HALT);

    // Decodes of registered state only (no pop bypass onto if_ready_out)
    assign if_ready_out      = !q_full && (state_q != ST_HALT);
    assign dec_has_instr_out = has_instr;
    assign dec_instr_out     = q_head.instr;
    assign dec_npc_out       = q_head.npc;
    assign halted_out        = (state_q == ST_HALT);

    assign q_wdata = '{instr: if_instr_in, npc: if_npc_in};
    assign q_push  = rdy_in && !flush_in && if_valid_in && if_ready_out;
    assign q_pop   = rdy_in && !flush_in && go;

    issue_queue #(
        .AW (IQ_ADDR_WIDTH),
        .DW ($bits(iq_entry_t))
    ) u_queue (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush_in && rdy_in),
        .push      (q_push),
        .wdata     (q_wdata),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Next-state: HALT is sticky until flush/reset
    always_comb begin
        state_d = state_q;
        if (state_q != ST_HALT) begin
            if (!has_instr)     state_d = ST_RUN;
            else if (!op_valid) state_d = ST_HALT;
            else if (go)        state_d = ST_RUN;
            else                state_d = ST_STALL;
        end
    end

    // State register and registered dispatch strobes/tag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_RUN;
            disp_rs_out  <= 1'b0;
            disp_slb_out <= 1'b0;
            disp_rob_out <= 1'b0;
            disp_tag_out <= '0;
        end else if (!rdy_in) begin
            disp_rs_out  <= 1'b0;
            disp_slb_out <= 1'b0;
            disp_rob_out <= 1'b0;
        end else if (flush_in) begin
            state_q      <= ST_RUN;
            disp_rs_out  <= 1'b0;
            disp_slb_out <= 1'b0;
            disp_rob_out <= 1'b0;
            disp_tag_out <= '0;
        end else begin
            state_q      <= state_d;
            disp_rob_out <= go;
            disp_rs_out  <= go && dec_to_rs_in;
            disp_slb_out <= go && dec_to_slb_in;
            if (go) disp_tag_out <= rob_tag_in;
        end
    end

`ifdef ISSUE_STALL_STAT_EN
    // Saturating statistics; survive flush, cleared only by reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cycles_out <= '0;
            disp_count_out   <= '0;
        end else if (rdy_in) begin
            if (state_q == ST_STALL && stall_cycles_out != '1)
                stall_cycles_out <= stall_cycles_out + 32'd1;
            if (!flush_in && go && disp_count_out != '1)
                disp_count_out <= disp_count_out + 32'd1;
        end
    end
`endif

endmodule
